// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor: computes i_a - i_b - i_borrow_in one bit per clock,
// LSB first, using a single borrow flip-flop. The result drives the same FND
// display path as the ripple-carry adder datapath.
//
// Handshake (start/busy/done):
//   i_start is sampled only while the FSM is IDLE. The edge that sees i_start=1
//   in IDLE accepts the operation and latches i_a, i_b and i_borrow_in. o_busy
//   is high from the next cycle until the last datapath step. o_done is a
//   one-cycle pulse in the cycle in which o_diff/o_borrow/o_negative first
//   show the new result. A start seen in any other state is dropped, not
//   queued.
//
// Optional feature (macro SERIAL_SUBTRACTOR_ABS_EN):
//   When defined, an ABS state follows SHIFT and o_diff carries the magnitude
//   of the result, with o_negative as its sign. When undefined, o_diff is the
//   raw wrapped difference and o_negative is tied to 0.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      synchronous active-high reset
//   i_start      request pulse, sampled only in IDLE
//   i_a          minuend (WIDTH bits), latched on accepted start
//   i_b          subtrahend (WIDTH bits), latched on accepted start
//   i_borrow_in  borrow-in, latched on accepted start
//   o_diff       difference (raw wrap, or magnitude with ABS option)
//   o_borrow     final borrow-out; 1 means the result is negative/underflow
//   o_negative   sign flag (ABS option only, else 0)
//   o_busy       high while an operation is in progress
//   o_done       one-cycle pulse when the result outputs are updated
//   o_state      debug view of the FSM state (0 IDLE, 1 SHIFT, 2 ABS, 3 DONE)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_borrow_in,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_negative,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ABS   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;

  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // One full-subtractor cell on the current LSBs.
  assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  // The counter holds the index of the bit being processed this cycle.
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (w_last) begin
`ifdef SERIAL_SUBTRACTOR_ABS_EN
          w_state_next = ST_ABS;
`else
          w_state_next = ST_DONE;
`endif
        end
      end
      ST_ABS:   w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

`ifdef SERIAL_SUBTRACTOR_ABS_EN
  logic r_negative;
`endif

  // Datapath
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ABS_EN
      r_negative <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_br  <= i_borrow_in;
            r_res <= '0;
            r_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          r_res <= w_res_next;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CW'(1);
`ifndef SERIAL_SUBTRACTOR_ABS_EN
          // Publish directly on the last bit; the shift register and borrow
          // FF are only valid for reading one cycle later.
          if (w_last) begin
            r_diff   <= w_res_next;
            r_borrow <= w_br_next;
          end
`endif
        end
`ifdef SERIAL_SUBTRACTOR_ABS_EN
        ST_ABS: begin
          // A negative result is replaced by its two's complement; for the
          // -2^WIDTH case this wraps to 0 while o_negative still reports 1.
          r_diff     <= r_br ? (~r_res + WIDTH'(1)) : r_res;
          r_negative <= r_br;
          r_borrow   <= r_br;
        end
`endif
        default: ;
      endcase
    end
  end

  assign o_diff     = r_diff;
  assign o_borrow   = r_borrow;
`ifdef SERIAL_SUBTRACTOR_ABS_EN
  assign o_negative = r_negative;
`else
  assign o_negative = 1'b0;
`endif
  assign o_busy     = (r_state == ST_SHIFT) || (r_state == ST_ABS);
  assign o_done     = (r_state == ST_DONE);
  assign o_state    = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor at WIDTH=4. Expected results are
// pushed into a queue when a start is driven and popped by a monitor when
// o_done pulses. Also tracks accept-to-done latency, busy length and, in the
// back-to-back sweep, the done-to-done period.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 4;
`ifdef SERIAL_SUBTRACTOR_ABS_EN
  localparam int LAT = W + 1;
  localparam bit ABS = 1'b1;
`else
  localparam int LAT = W;
  localparam bit ABS = 1'b0;
`endif
  // Accept cycle, LAT processing cycles ending in done, then DONE->IDLE gives
  // one IDLE cycle before the next accept.
  localparam int PERIOD = LAT + 2;

  logic         clk;
  logic         i_reset;
  logic         i_start;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_borrow_in;
  logic [W-1:0] o_diff;
  logic         o_borrow;
  logic         o_negative;
  logic         o_busy;
  logic         o_done;
  logic [1:0]   o_state;

  serial_subtractor #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_borrow_in (i_borrow_in),
    .o_diff      (o_diff),
    .o_borrow    (o_borrow),
    .o_negative  (o_negative),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_state     (o_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W+1:0] exp_q[$];   // {diff, borrow, negative}
  int           acc_q[$];   // cycle count of the accept edge
  int  busy_cnt  = 0;
  bit  sweep_on  = 1'b0;
  bit  have_prev = 1'b0;
  int  last_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: act=%0d req=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected outputs from a raw difference and borrow.
  function automatic logic [W+1:0] to_exp(input logic [W-1:0] raw, input logic brw);
    logic [W-1:0] d;
    logic         neg;
    d   = raw;
    neg = 1'b0;
    if (ABS && brw) begin
      d   = ~raw + W'(1);
      neg = 1'b1;
    end
    return {d, brw, neg};
  endfunction

  function automatic logic [W+1:0] model(input int a, input int b, input int bin);
    int r;
    r = a - b - bin;
    return to_exp(r[W-1:0], (a < b + bin));
  endfunction

  always @(negedge clk) begin
    if (o_done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: act=1 req=0 (t=%0t)", $time);
      end else begin
        logic [W+1:0] e;
        int           acc;
        e   = exp_q.pop_front();
        acc = acc_q.pop_front();
        chk("diff",     o_diff,     e[W+1:2]);
        chk("borrow",   o_borrow,   e[1]);
        chk("negative", o_negative, e[0]);
        chk("latency",  cyc - acc,  LAT);
        chk("busy_len", busy_cnt,   LAT);
        if (sweep_on) begin
          if (have_prev) chk("period", cyc - last_done, PERIOD);
          have_prev = 1'b1;
          last_done = cyc;
        end
      end
      busy_cnt = 0;
    end else if (!o_busy) begin
      busy_cnt = 0;
    end else begin
      busy_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input int a, input int b, input int bin, input bit push);
    int k;
    for (k = 0; k < 64; k++) begin
      if (o_state == 2'd0) break;
      @(negedge clk);
    end
    if (o_state != 2'd0) chk("wait_idle", o_state, 0);
    i_a         = W'(a);
    i_b         = W'(b);
    i_borrow_in = bin[0];
    i_start     = 1'b1;
    if (push) begin
      exp_q.push_back(model(a, b, bin));
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0 && o_state == 2'd0) break;
      @(negedge clk);
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int           a;
    int           b;
    int           bin;
    logic [W-1:0] diff;
    logic         borrow;
  } vec_t;

  vec_t tab[10];

  initial begin
    tab[0] = '{9,  3,  0, 4'd6,  1'b0};
    tab[1] = '{3,  9,  0, 4'd10, 1'b1};
    tab[2] = '{0,  0,  1, 4'd15, 1'b1};
    tab[3] = '{0,  15, 1, 4'd0,  1'b1};
    tab[4] = '{15, 15, 0, 4'd0,  1'b0};
    tab[5] = '{15, 0,  1, 4'd14, 1'b0};
    tab[6] = '{7,  8,  0, 4'd15, 1'b1};
    tab[7] = '{8,  7,  1, 4'd0,  1'b0};
    tab[8] = '{5,  5,  1, 4'd15, 1'b1};
    tab[9] = '{15, 0,  0, 4'd15, 1'b0};

    i_reset     = 1'b1;
    i_start     = 1'b0;
    i_a         = '0;
    i_b         = '0;
    i_borrow_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_diff",   o_diff,     0);
    chk("rst_borrow", o_borrow,   0);
    chk("rst_neg",    o_negative, 0);
    chk("rst_busy",   o_busy,     0);
    chk("rst_done",   o_done,     0);
    chk("rst_state",  o_state,    0);
    i_reset = 1'b0;
    @(negedge clk);

    // Table vectors: hand-derived raw results, passed through the sign rule.
    for (int i = 0; i < 10; i++) begin
      int k;
      for (k = 0; k < 64; k++) begin
        if (o_state == 2'd0) break;
        @(negedge clk);
      end
      i_a         = W'(tab[i].a);
      i_b         = W'(tab[i].b);
      i_borrow_in = tab[i].bin[0];
      i_start     = 1'b1;
      exp_q.push_back(to_exp(tab[i].diff, tab[i].borrow));
      acc_q.push_back(cyc + 1);
      @(negedge clk);
      i_start = 1'b0;
    end
    drain();

    // Starts during SHIFT are ignored and input changes do not disturb it.
    start_op(12, 5, 0, 1'b1);
    i_a = 4'd3; i_b = 4'd9; i_borrow_in = 1'b1; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    // Hold a start across the DONE cycle: only the following IDLE accepts it.
    begin
      int k;
      for (k = 0; k < 64; k++) begin
        if (o_state == 2'd3) break;
        @(negedge clk);
      end
      chk("reach_done", o_state, 3);
    end
    i_a = 4'd1; i_b = 4'd0; i_borrow_in = 1'b0; i_start = 1'b1;
    @(negedge clk);
    chk("idle_after_done", o_state, 0);
    exp_q.push_back(model(1, 0, 0));
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    i_start = 1'b0;
    drain();

    // Reset mid-operation discards the result with no done pulse.
    start_op(8, 1, 0, 1'b0);
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_diff",   o_diff,     0);
    chk("mid_rst_borrow", o_borrow,   0);
    chk("mid_rst_neg",    o_negative, 0);
    chk("mid_rst_busy",   o_busy,     0);
    chk("mid_rst_done",   o_done,     0);
    chk("mid_rst_state",  o_state,    0);
    i_reset = 1'b0;
    repeat (W + 3) @(negedge clk);
    start_op(5, 5, 0, 1'b1);
    drain();

    // Exhaustive back-to-back sweep.
    have_prev = 1'b0;
    sweep_on  = 1'b1;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int bin = 0; bin < 2; bin++)
          start_op(a, b, bin, 1'b1);
    drain();
    sweep_on = 1'b0;

    // A few random operations with random idle gaps.
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), 1'b1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
